// File: rtl/prog_loader_pkg.sv
// Shared opcode map, loader state type and the instruction encode helper.
package prog_loader_pkg;

   typedef enum logic [2:0] {LW, SW, SET, BNE, PAR, ADD, XOR, LSOR} op_mne;

   localparam logic [2:0] kLSW  = 3'b000;
   localparam logic [2:0] kSET  = 3'b010;
   localparam logic [2:0] kBNE  = 3'b011;
   localparam logic [2:0] kPAR  = 3'b100;
   localparam logic [2:0] kADD  = 3'b101;
   localparam logic [2:0] kXOR  = 3'b110;
   localparam logic [2:0] kLSOR = 3'b111;

   localparam int kLSW_SW_BIT = 5;

   localparam logic [1:0] kErrNone     = 2'b00;
   localparam logic [1:0] kErrOperand  = 2'b01;
   localparam logic [1:0] kErrOverflow = 2'b10;

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} loader_state;

   // LW and SW share one opcode; the store flag lives in the top operand bit.
   function automatic logic [8:0] encode_instr(op_mne op, logic [5:0] operand);
      logic [8:0] word;
      word = {kLSW, operand};
      case (op)
         LW: begin
            word = {kLSW, operand};
            word[kLSW_SW_BIT] = 1'b0;
         end
         SW: begin
            word = {kLSW, operand};
            word[kLSW_SW_BIT] = 1'b1;
         end
         SET:     word = {kSET, operand};
         BNE:     word = {kBNE, operand};
         PAR:     word = {kPAR, operand};
         ADD:     word = {kADD, operand};
         XOR:     word = {kXOR, operand};
         LSOR:    word = {kLSOR, operand};
         default: word = {kLSW, operand};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/prog_loader_encoder.sv
// instr_encoder: mnemonic + operand to 9-bit machine word, purely combinational.
// Flags LW/SW operands that do not fit the 5-bit address field.
module instr_encoder
   import prog_loader_pkg::*;
(
   input  op_mne       op,
   input  logic [5:0]  operand,
   output logic [8:0]  word,
   output logic        illegal
);

   always_comb begin
      word    = encode_instr(op, operand);
      illegal = ((op == LW) || (op == SW)) && operand[kLSW_SW_BIT];
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: encodes a handshaked item stream and writes it to instruction memory from address 0.
// Write strobe, address, data and count appear one cycle after the accepting handshake.
// in_ready is a decode of the registered state: high for the whole LOAD session, low otherwise.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int A_W = 10
)
(
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic           in_valid,
   input  op_mne          in_op,
   input  logic [5:0]     in_operand,
   input  logic           in_last,
   output logic           in_ready,
   output logic           wr_en,
   output logic [A_W-1:0] wr_addr,
   output logic [8:0]     wr_data,
   output logic [A_W:0]   count,
   output logic           done,
   output logic           err,
   output logic [1:0]     err_code
);

   loader_state    state, nextState;
   logic [A_W-1:0] ptr;
   logic [8:0]     encWord;
   logic           encIllegal;
   logic           handshake;
   logic           ptrFull;
   logic           doWrite;
   logic           clrSession;
   logic           setErr;
   logic [1:0]     nextErrCode;

   instr_encoder uEnc (
      .op      (in_op),
      .operand (in_operand),
      .word    (encWord),
      .illegal (encIllegal)
   );

   assign in_ready  = (state == LOAD);
   assign done      = (state == DONE);
   assign err       = (state == ERR);
   assign handshake = in_valid & in_ready;
   assign ptrFull   = &ptr;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState   = state;
      doWrite     = 1'b0;
      clrSession  = 1'b0;
      setErr      = 1'b0;
      nextErrCode = kErrNone;
      case (state)
         IDLE, DONE, ERR: begin
            if (Start) begin
               nextState  = LOAD;
               clrSession = 1'b1;
            end
         end
         LOAD: begin
            if (handshake) begin
               if (encIllegal) begin
                  nextState   = ERR;
                  setErr      = 1'b1;
                  nextErrCode = kErrOperand;
               end else begin
                  doWrite = 1'b1;
                  // A last item wins over a full memory: the final word still fits.
                  if (in_last) begin
                     nextState = DONE;
                  end else if (ptrFull) begin
                     nextState   = ERR;
                     setErr      = 1'b1;
                     nextErrCode = kErrOverflow;
                  end
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr      <= '0;
         count    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         err_code <= kErrNone;
      end else begin
         wr_en <= doWrite;
         if (clrSession) begin
            ptr      <= '0;
            count    <= '0;
            err_code <= kErrNone;
         end
         if (doWrite) begin
            wr_addr <= ptr;
            wr_data <= encWord;
            ptr     <= ptr + 1'b1;
            count   <= count + 1'b1;
         end
         if (setErr) err_code <= nextErrCode;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed bench for prog_loader with a queue-based write scoreboard.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          in_valid;
   op_mne         in_op;
   logic [5:0]    in_operand;
   logic          in_last;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [8:0]    wr_data;
   logic [AW:0]   count;
   logic          done;
   logic          err;
   logic [1:0]    err_code;

   prog_loader #(.A_W(AW)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .in_valid   (in_valid),
      .in_op      (in_op),
      .in_operand (in_operand),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .count      (count),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 Clk = ~Clk;

   int cycleCnt = 0;
   always @(posedge Clk) cycleCnt <= cycleCnt + 1;

   typedef struct {
      int addr;
      int data;
      int cnt;
      int cyc;
   } wrExp_t;

   wrExp_t expQ[$];
   wrExp_t monE;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 idle, 1 loading, 2 done, 3 error.
   int mSt   = 0;
   int mPtr  = 0;
   int mCount = 0;
   int mErr  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int opcodeOf(op_mne op);
      case (op)
         SET:     return 2;
         BNE:     return 3;
         PAR:     return 4;
         ADD:     return 5;
         XOR:     return 6;
         LSOR:    return 7;
         default: return 0;
      endcase
   endfunction

   function automatic int modelEncode(op_mne op, logic [5:0] opd);
      int f;
      if (op == LW)      f = int'(opd) % 32;
      else if (op == SW) f = 32 + int'(opd) % 32;
      else               f = int'(opd);
      return opcodeOf(op) * 64 + f;
   endfunction

   task automatic checkStatus(input string tag);
      chk({tag, " in_ready"}, in_ready, mSt == 1);
      chk({tag, " done"},     done,     mSt == 2);
      chk({tag, " err"},      err,      mSt == 3);
      chk({tag, " err_code"}, err_code, mErr);
      chk({tag, " count"},    count,    mCount);
   endtask

   task automatic checkResetVals(input string tag);
      chk({tag, " in_ready"}, in_ready, 0);
      chk({tag, " wr_en"},    wr_en,    0);
      chk({tag, " done"},     done,     0);
      chk({tag, " err"},      err,      0);
      chk({tag, " wr_addr"},  wr_addr,  0);
      chk({tag, " wr_data"},  wr_data,  0);
      chk({tag, " count"},    count,    0);
      chk({tag, " err_code"}, err_code, 0);
   endtask

   // One clock cycle of stimulus; called #1 after a rising edge.
   task automatic cyc(input bit v, input op_mne op, input logic [5:0] opd,
                      input bit last, input bit st, input string tag);
      wrExp_t e;
      in_valid   = v;
      in_op      = op;
      in_operand = opd;
      in_last    = last;
      Start      = st;
      if (mSt != 1) begin
         if (st) begin
            mSt = 1; mPtr = 0; mCount = 0; mErr = 0;
         end
      end else if (v) begin
         if ((op == LW || op == SW) && opd >= 6'd32) begin
            mSt = 3; mErr = 1;
         end else begin
            mCount++;
            e.addr = mPtr;
            e.data = modelEncode(op, opd);
            e.cnt  = mCount;
            e.cyc  = cycleCnt + 1;
            expQ.push_back(e);
            mPtr++;
            if (last) mSt = 2;
            else if (mCount == DEPTH) begin
               mSt = 3; mErr = 2;
            end
         end
      end
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      Start    = 1'b0;
      checkStatus(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, LW, 6'd0, 0, 0, "idle");
   endtask

   always @(negedge Clk) begin
      if (wr_en) begin
         if (expQ.size() == 0) begin
            chk("unexpected wr_en", wr_en, 0);
         end else begin
            monE = expQ.pop_front();
            chk("wr_addr",  wr_addr,  monE.addr);
            chk("wr_data",  wr_data,  monE.data);
            chk("wr count", count,    monE.cnt);
            chk("wr cycle", cycleCnt, monE.cyc);
         end
      end
   end

   initial begin
      logic [2:0] r;
      logic [5:0] opd;
      op_mne      op;
      Reset = 1'b1; Start = 1'b0; in_valid = 1'b0; in_op = LW;
      in_operand = '0; in_last = 1'b0;
      #2;
      checkResetVals("reset");
      @(posedge Clk); @(posedge Clk); #1;
      Reset = 1'b0;

      // Encode sweep, last item lands on the final address.
      cyc(0, LW, 0, 0, 1, "start sweep");
      cyc(1, LW,   6'd5,  0, 0, "LW 5");
      cyc(1, SW,   6'd5,  0, 0, "SW 5");
      cyc(1, SET,  6'd63, 0, 0, "SET 63");
      cyc(1, BNE,  6'd10, 0, 0, "BNE 10");
      cyc(1, PAR,  6'd0,  0, 0, "PAR 0");
      cyc(1, ADD,  6'd3,  0, 0, "ADD 3");
      cyc(1, XOR,  6'd7,  0, 0, "XOR 7");
      cyc(1, LSOR, 6'd1,  1, 0, "LSOR 1");
      chk("sweep done", done, 1);
      chk("sweep count", count, 8);
      idle(2);

      // Illegal operand.
      cyc(0, LW, 0, 0, 1, "start illegal");
      cyc(1, ADD, 6'd1,  0, 0, "ADD 1");
      cyc(1, LW,  6'h20, 0, 0, "LW 0x20");
      chk("illegal err", err, 1);
      chk("illegal code", err_code, 1);
      chk("illegal count", count, 1);
      idle(1);
      cyc(0, LW, 0, 0, 1, "restart after err");
      chk("restart in_ready", in_ready, 1);

      // Overflow: one more item than fits, none marked last.
      for (int i = 0; i <= DEPTH; i++) cyc(1, ADD, 6'(i), 0, 0, "overflow");
      chk("overflow code", err_code, 2);
      idle(1);

      // Last item coincides with the full memory.
      cyc(0, LW, 0, 0, 1, "start full last");
      for (int i = 0; i < DEPTH; i++) cyc(1, XOR, 6'(i + 8), i == DEPTH - 1, 0, "full last");
      chk("full last done", done, 1);
      chk("full last err", err, 0);
      idle(1);

      // Handshake gaps with a Start pulse mid-session.
      cyc(0, LW, 0, 0, 1, "start gaps");
      cyc(1, SET, 6'd11, 0, 0, "gap v1");
      cyc(0, SET, 6'd12, 0, 1, "gap v0 start");
      cyc(1, BNE, 6'd13, 0, 0, "gap v1");
      cyc(1, PAR, 6'd14, 0, 0, "gap v1");
      cyc(0, PAR, 6'd15, 0, 0, "gap v0");
      cyc(1, SW,  6'd16, 0, 0, "gap v1");
      chk("gaps count", count, 4);
      idle(1);

      // Reset while a handshake is pending.
      in_valid = 1'b1; in_op = ADD; in_operand = 6'd9;
      #3;
      Reset = 1'b1;
      #1;
      checkResetVals("async reset");
      in_valid = 1'b0;
      mSt = 0; mPtr = 0; mCount = 0; mErr = 0;
      @(posedge Clk); @(posedge Clk); #1;
      Reset = 1'b0;
      checkStatus("after reset");
      cyc(0, LW, 0, 0, 1, "start post reset");
      cyc(1, ADD, 6'd2, 1, 0, "post reset item");

      // Randomized sessions.
      for (int i = 0; i < 600; i++) begin
         r   = 3'($urandom_range(0, 7));
         op  = op_mne'(r);
         opd = 6'($urandom_range(0, 63));
         if ((op == LW || op == SW) && $urandom_range(0, 9) != 0) opd = opd % 6'd32;
         cyc($urandom_range(0, 3) != 0, op, opd, $urandom_range(0, 11) == 0,
             (mSt != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0),
             "random");
      end

      idle(3);
      chk("scoreboard drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
